elevator_plant: RTL and testbench

ELEVATOR_PLANT -- requirements
Module: elevator_plant

---
 rtl/elevator_plant.sv | 168 ++++++++++++++++
 tb/tb_elevator_plant.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_plant.sv
// Elevator car and door plant model: registered engine/door FSMs with travel and stroke timers,
// a door/motion interlock and a sticky fault flag.
module elevator_plant #(
  parameter int unsigned FLOORS       = 8,
  parameter int unsigned FLOOR_W      = 3,
  parameter int unsigned DELAY_ENGINE = 10,
  parameter int unsigned DELAY_DOOR   = 10,
  parameter int unsigned CNT_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         engine,
  input  logic [1:0]         door,
  output logic [FLOOR_W-1:0] floor,
  output logic               at_floor,
  output logic               sensor_up,
  output logic               sensor_down,
  output logic [1:0]         sensor_door,
  output logic               moving,
  output logic               fault,
  output logic [CNT_W-1:0]   counter_engine,
  output logic [CNT_W-1:0]   counter_door
);

  typedef enum logic [1:0] {
    EngIdle = 2'b00,
    EngUp   = 2'b01,
    EngDown = 2'b10
  } eng_state_e;

  // Encoding is exposed directly on sensor_door.
  typedef enum logic [1:0] {
    DoorClosed  = 2'b00,
    DoorOpening = 2'b01,
    DoorClosing = 2'b10,
    DoorOpen    = 2'b11
  } door_state_e;

  localparam logic [FLOOR_W-1:0] TopFloor = FLOOR_W'(FLOORS - 1);
  localparam logic [CNT_W-1:0]   EngLast  = CNT_W'(DELAY_ENGINE - 1);
  localparam logic [CNT_W-1:0]   DoorLast = CNT_W'(DELAY_DOOR - 1);

  eng_state_e         eng_state_q, eng_state_d;
  door_state_e        door_state_q, door_state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [CNT_W-1:0]   cnt_eng_q, cnt_eng_d;
  logic [CNT_W-1:0]   cnt_door_q, cnt_door_d;
  logic               fault_q, fault_d;

  logic cmd_up, cmd_down, cmd_illegal, cmd_stop;
  logic cmd_open, cmd_close;

  assign cmd_stop    = (engine == 2'b00);
  assign cmd_up      = (engine == 2'b01);
  assign cmd_down    = (engine == 2'b10);
  assign cmd_illegal = (engine == 2'b11);
  assign cmd_open    = (door == 2'b01);
  assign cmd_close   = (door == 2'b10);

  // Engine: anything other than an accepted move lands in idle with the counter cleared.
  always_comb begin
    eng_state_d = EngIdle;
    cnt_eng_d   = '0;
    floor_d     = floor_q;
    fault_d     = fault_q;
    if (cmd_illegal) begin
      fault_d = 1'b1;
    end else if (cmd_up || cmd_down) begin
      if (door_state_q != DoorClosed) begin
        fault_d = 1'b1;
      end else if ((cmd_up && (floor_q != TopFloor)) || (cmd_down && (floor_q != '0))) begin
        if (cmd_up) begin
          eng_state_d = EngUp;
        end else begin
          eng_state_d = EngDown;
        end
        if ((eng_state_q != EngIdle) && (eng_state_q != eng_state_d)) begin
          // Reversal restarts the current floor's travel from zero.
          cnt_eng_d = '0;
        end else if (cnt_eng_q == EngLast) begin
          cnt_eng_d = '0;
          if (cmd_up) begin
            floor_d = floor_q + FLOOR_W'(1);
          end else begin
            floor_d = floor_q - FLOOR_W'(1);
          end
        end else begin
          cnt_eng_d = cnt_eng_q + CNT_W'(1);
        end
      end
    end
  end

  // Door: uses pre-edge engine counter so it never opens while the car is between floors.
  always_comb begin
    door_state_d = door_state_q;
    cnt_door_d   = cnt_door_q;
    case (door_state_q)
      DoorClosed: begin
        if (cmd_open && cmd_stop && (cnt_eng_q == '0)) begin
          door_state_d = DoorOpening;
          cnt_door_d   = '0;
        end
      end
      DoorOpening: begin
        if (cmd_close) begin
          door_state_d = DoorClosing;
          cnt_door_d   = '0;
        end else if (cnt_door_q == DoorLast) begin
          door_state_d = DoorOpen;
          cnt_door_d   = '0;
        end else begin
          cnt_door_d = cnt_door_q + CNT_W'(1);
        end
      end
      DoorClosing: begin
        if (cmd_open) begin
          door_state_d = DoorOpening;
          cnt_door_d   = '0;
        end else if (cnt_door_q == DoorLast) begin
          door_state_d = DoorClosed;
          cnt_door_d   = '0;
        end else begin
          cnt_door_d = cnt_door_q + CNT_W'(1);
        end
      end
      DoorOpen: begin
        if (cmd_close) begin
          door_state_d = DoorClosing;
          cnt_door_d   = '0;
        end
      end
      default: begin
        door_state_d = DoorClosed;
        cnt_door_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_state_q  <= EngIdle;
      door_state_q <= DoorClosed;
      floor_q      <= '0;
      cnt_eng_q    <= '0;
      cnt_door_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      eng_state_q  <= eng_state_d;
      door_state_q <= door_state_d;
      floor_q      <= floor_d;
      cnt_eng_q    <= cnt_eng_d;
      cnt_door_q   <= cnt_door_d;
      fault_q      <= fault_d;
    end
  end

  assign floor          = floor_q;
  assign at_floor       = (cnt_eng_q == '0);
  assign sensor_up      = (floor_q == TopFloor);
  assign sensor_down    = (floor_q == '0);
  assign sensor_door    = door_state_q;
  assign moving         = (eng_state_q != EngIdle);
  assign fault          = fault_q;
  assign counter_engine = cnt_eng_q;
  assign counter_door   = cnt_door_q;

endmodule

// File: tb/tb_elevator_plant.sv
// Self-checking bench for elevator_plant: table of {command, cycles, expected outputs}
// plus hand-written reset and fault sequences, all checked through an expectation queue.
module tb_elevator_plant;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] engine;
  logic [1:0] door;
  logic [2:0] floor;
  logic       at_floor, sensor_up, sensor_down, moving, fault;
  logic [1:0] sensor_door;
  logic [4:0] counter_engine, counter_door;

  elevator_plant #(
    .FLOORS      (8),
    .FLOOR_W     (3),
    .DELAY_ENGINE(10),
    .DELAY_DOOR  (10),
    .CNT_W       (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .engine        (engine),
    .door          (door),
    .floor         (floor),
    .at_floor      (at_floor),
    .sensor_up     (sensor_up),
    .sensor_down   (sensor_down),
    .sensor_door   (sensor_door),
    .moving        (moving),
    .fault         (fault),
    .counter_engine(counter_engine),
    .counter_door  (counter_door)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] floor;
    logic       at_floor;
    logic       up;
    logic       down;
    logic [1:0] sdoor;
    logic       moving;
    logic       fault;
    logic [4:0] ce;
    logic [4:0] cd;
  } obs_t;

  typedef struct {
    logic [1:0] eng;
    logic [1:0] dr;
    int         n;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // at_floor/sensor_up/sensor_down follow from counter and floor by definition.
  function automatic obs_t mk(input int fl, input int sd, input bit mv, input bit f,
                              input int ce, input int cd);
    obs_t o;
    o.floor    = 3'(fl);
    o.at_floor = (ce == 0);
    o.up       = (fl == 7);
    o.down     = (fl == 0);
    o.sdoor    = 2'(sd);
    o.moving   = mv;
    o.fault    = f;
    o.ce       = 5'(ce);
    o.cd       = 5'(cd);
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.floor    = floor;
    o.at_floor = at_floor;
    o.up       = sensor_up;
    o.down     = sensor_down;
    o.sdoor    = sensor_door;
    o.moving   = moving;
    o.fault    = fault;
    o.ce       = counter_engine;
    o.cd       = counter_door;
    return o;
  endfunction

  task automatic add(input logic [1:0] e, input logic [1:0] d, input int n, input obs_t x);
    vec_t v;
    v.eng = e;
    v.dr  = d;
    v.n   = n;
    v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [1:0] e, input logic [1:0] d, input int n);
    engine = e;
    door   = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name);
    obs_t a;
    obs_t x;
    a = actual();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expectation queued", name);
    end else begin
      x = exp_q.pop_front();
      if (a !== x) begin
        failures++;
        $display("FAIL %s: got floor=%0d at=%b up=%b dn=%b door=%b mv=%b flt=%b ce=%0d cd=%0d | want floor=%0d at=%b up=%b dn=%b door=%b mv=%b flt=%b ce=%0d cd=%0d",
                 name, a.floor, a.at_floor, a.up, a.down, a.sdoor, a.moving, a.fault, a.ce,
                 a.cd, x.floor, x.at_floor, x.up, x.down, x.sdoor, x.moving, x.fault, x.ce,
                 x.cd);
      end
    end
  endtask

  // Short asynchronous pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    engine = 2'b00;
    door   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //  eng    door   n    floor door mv flt ce cd
    add(2'd0, 2'd0, 1,  mk(0, 0, 0, 0, 0, 0));
    add(2'd1, 2'd0, 1,  mk(0, 0, 1, 0, 1, 0));
    add(2'd1, 2'd0, 9,  mk(1, 0, 1, 0, 0, 0));
    add(2'd1, 2'd0, 60, mk(7, 0, 1, 0, 0, 0));
    add(2'd1, 2'd0, 1,  mk(7, 0, 0, 0, 0, 0));
    add(2'd2, 2'd0, 40, mk(3, 0, 1, 0, 0, 0));
    add(2'd2, 2'd0, 5,  mk(3, 0, 1, 0, 5, 0));
    add(2'd0, 2'd0, 1,  mk(3, 0, 0, 0, 0, 0));
    add(2'd1, 2'd0, 6,  mk(3, 0, 1, 0, 6, 0));
    add(2'd2, 2'd0, 1,  mk(3, 0, 1, 0, 0, 0));
    add(2'd2, 2'd0, 9,  mk(3, 0, 1, 0, 9, 0));
    add(2'd2, 2'd0, 1,  mk(2, 0, 1, 0, 0, 0));
    add(2'd0, 2'd0, 1,  mk(2, 0, 0, 0, 0, 0));
    add(2'd0, 2'd1, 1,  mk(2, 1, 0, 0, 0, 0));
    add(2'd0, 2'd1, 9,  mk(2, 1, 0, 0, 0, 9));
    add(2'd0, 2'd1, 1,  mk(2, 3, 0, 0, 0, 0));
    add(2'd0, 2'd0, 3,  mk(2, 3, 0, 0, 0, 0));
    add(2'd0, 2'd2, 1,  mk(2, 2, 0, 0, 0, 0));
    add(2'd0, 2'd0, 4,  mk(2, 2, 0, 0, 0, 4));
    add(2'd0, 2'd1, 1,  mk(2, 1, 0, 0, 0, 0));
    add(2'd0, 2'd0, 4,  mk(2, 1, 0, 0, 0, 4));
    add(2'd0, 2'd2, 1,  mk(2, 2, 0, 0, 0, 0));
    add(2'd0, 2'd0, 10, mk(2, 0, 0, 0, 0, 0));
    add(2'd0, 2'd2, 1,  mk(2, 0, 0, 0, 0, 0));
    add(2'd1, 2'd0, 3,  mk(2, 0, 1, 0, 3, 0));
    add(2'd1, 2'd1, 1,  mk(2, 0, 1, 0, 4, 0));
    add(2'd0, 2'd1, 1,  mk(2, 0, 0, 0, 0, 0));
    add(2'd0, 2'd1, 1,  mk(2, 1, 0, 0, 0, 0));
    add(2'd0, 2'd0, 10, mk(2, 3, 0, 0, 0, 0));
    add(2'd1, 2'd0, 1,  mk(2, 3, 0, 1, 0, 0));
    add(2'd0, 2'd0, 3,  mk(2, 3, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      step(vecs[i].eng, vecs[i].dr, vecs[i].n);
      check($sformatf("vec%0d", i));
    end

    // Down at the bottom floor is ignored without fault.
    pulse_reset();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    step(2'd2, 2'd0, 3);
    check("down_at_bottom");

    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    step(2'd3, 2'd0, 1);
    check("illegal_engine");

    exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
    step(2'd0, 2'd0, 2);
    check("illegal_fault_sticky");

    // Reset mid-travel: outputs must clear before the next clock edge.
    pulse_reset();
    exp_q.push_back(mk(3, 0, 1, 0, 5, 0));
    step(2'd1, 2'd0, 35);
    check("travel_to_floor3");

    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_travel");
    engine = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-stroke.
    exp_q.push_back(mk(0, 1, 0, 0, 0, 4));
    step(2'd0, 2'd1, 5);
    check("door_mid_stroke");

    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_door");
    door = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
